// File: rtl/acia_rx_buffer.sv
// rtl/acia_rx_buffer.sv - 8N1 16x-oversampled receiver with byte FIFO, 4-register bus port, IRQ and RTS
// Optional RTS hysteresis is built when ACIA_RX_RTS_EN is defined; otherwise rtsb is tied low.
module acia_rx_buffer #(
   parameter int DEPTH    = 16,
   parameter int BAUD_DIV = 13,
   parameter int RTS_HI   = 12,
   parameter int RTS_LO   = 4
) (
   input  logic       clk,
   input  logic       resb,
   input  logic       rxd,
   input  logic       cs,
   input  logic       rwb,
   input  logic [1:0] rs,
   input  logic       strobe,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irqb,
   output logic       rtsb
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [7:0]    DIV_RST = 8'(BAUD_DIV);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   logic            rx_s1, rx_s2, rx_prev, rx_fall;
   logic [7:0]      tick_cnt, divisor;
   logic            tick;
   rx_state_t       state, state_n;
   logic [3:0]      scnt, scnt_n;
   logic [2:0]      bit_cnt, bit_cnt_n;
   logic [7:0]      shreg, shreg_n;
   logic            rx_push, rx_ferr;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [LW-1:0]   level;
   logic            full, nempty, pop, push_ok;
   logic            wr_stb, rd_stb;
   logic            ovr, fe, ie, irq;

   always_ff @(posedge clk or negedge resb) begin
      if (!resb) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rxd;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   assign rx_fall = rx_prev & ~rx_s2;
   assign tick    = (tick_cnt == 8'd0);

   // A new divisor is only picked up when the counter reloads.
   always_ff @(posedge clk or negedge resb) begin
      if (!resb)     tick_cnt <= DIV_RST - 8'd1;
      else if (tick) tick_cnt <= divisor - 8'd1;
      else           tick_cnt <= tick_cnt - 8'd1;
   end

   always_ff @(posedge clk or negedge resb) begin
      if (!resb) begin
         state   <= IDLE;
         scnt    <= 4'd0;
         bit_cnt <= 3'd0;
         shreg   <= 8'h00;
      end else begin
         state   <= state_n;
         scnt    <= scnt_n;
         bit_cnt <= bit_cnt_n;
         shreg   <= shreg_n;
      end
   end

   always_comb begin
      state_n   = state;
      scnt_n    = scnt;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      rx_push   = 1'b0;
      rx_ferr   = 1'b0;
      case (state)
         IDLE: begin
            if (rx_fall) begin
               state_n = START;
               scnt_n  = 4'd0;
            end
         end
         START: begin
            if (tick) begin
               if (scnt == 4'd7) begin
                  scnt_n    = 4'd0;
                  bit_cnt_n = 3'd0;
                  state_n   = rx_s2 ? IDLE : DATA;
               end else begin
                  scnt_n = scnt + 4'd1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (scnt == 4'd15) begin
                  shreg_n   = {rx_s2, shreg[7:1]};
                  bit_cnt_n = bit_cnt + 3'd1;
                  scnt_n    = 4'd0;
                  if (bit_cnt == 3'd7) state_n = STOP;
               end else begin
                  scnt_n = scnt + 4'd1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (scnt == 4'd15) begin
                  state_n = IDLE;
                  rx_push = rx_s2;
                  rx_ferr = ~rx_s2;
               end else begin
                  scnt_n = scnt + 4'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign wr_stb  = cs & ~rwb & strobe;
   assign rd_stb  = cs & rwb & strobe;
   assign full    = (level == DEPTH_L);
   assign nempty  = (level != '0);
   assign pop     = rd_stb & (rs == 2'd0) & nempty;
   // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
   assign push_ok = rx_push & (~full | pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= shreg;
   end

   always_ff @(posedge clk or negedge resb) begin
      if (!resb) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push_ok) wptr <= wptr + AW'(1);
         if (pop)     rptr <= rptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resb) begin
      if (!resb) begin
         ovr     <= 1'b0;
         fe      <= 1'b0;
         ie      <= 1'b0;
         divisor <= DIV_RST;
      end else begin
         if (wr_stb && rs == 2'd1) begin
            ovr <= 1'b0;
            fe  <= 1'b0;
         end
         if (rx_push && full && !pop) ovr <= 1'b1;
         if (rx_ferr)                 fe  <= 1'b1;
         if (wr_stb && rs == 2'd2) ie <= din[0];
         if (wr_stb && rs == 2'd3) divisor <= (din == 8'h00) ? 8'h01 : din;
      end
   end

   assign irq  = ie & (nempty | ovr | fe);
   assign irqb = ~irq;

   always_comb begin
      dout = 8'h00;
      if (cs) begin
         case (rs)
            2'd0:    dout = nempty ? mem[rptr] : 8'h00;
            2'd1:    dout = {irq, 3'b000, ovr, fe, full, nempty};
            2'd2:    dout = {7'b0000000, ie};
            default: dout = {{(8-LW){1'b0}}, level};
         endcase
      end
   end

`ifdef ACIA_RX_RTS_EN
   localparam logic [LW-1:0] RTS_HI_L = LW'(RTS_HI);
   localparam logic [LW-1:0] RTS_LO_L = LW'(RTS_LO);
   logic rts_q;

   // Between the thresholds the previous value is held.
   always_ff @(posedge clk or negedge resb) begin
      if (!resb)                  rts_q <= 1'b0;
      else if (level >= RTS_HI_L) rts_q <= 1'b1;
      else if (level <= RTS_LO_L) rts_q <= 1'b0;
   end

   assign rtsb = rts_q;
`else
   assign rtsb = 1'b0;
`endif

endmodule

// File: tb/tb_acia_rx_buffer.sv
// tb/tb_acia_rx_buffer.sv - directed plus randomized bench for acia_rx_buffer against a queue-based model
module tb_acia_rx_buffer;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       resb = 1'b0;
   logic       rxd = 1'b1;
   logic       cs = 1'b0;
   logic       rwb = 1'b1;
   logic [1:0] rs = 2'd1;
   logic       strobe = 1'b0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       irqb, rtsb;

   int n_checks = 0;
   int n_pass = 0;

   logic [7:0] q[$];
   logic       m_ovr = 1'b0, m_fe = 1'b0, m_ie = 1'b0, m_rts = 1'b0;
   int         m_div = 13;

   acia_rx_buffer #(.DEPTH(DEPTH), .BAUD_DIV(13), .RTS_HI(12), .RTS_LO(4)) dut (
      .clk(clk), .resb(resb), .rxd(rxd), .cs(cs), .rwb(rwb), .rs(rs),
      .strobe(strobe), .din(din), .dout(dout), .irqb(irqb), .rtsb(rtsb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [7:0] m_status();
      logic ne, irq;
      ne  = (q.size() != 0);
      irq = m_ie & (ne | m_ovr | m_fe);
      return {irq, 3'b000, m_ovr, m_fe, q.size() == DEPTH, ne};
   endfunction

   function automatic void m_rts_update();
`ifdef ACIA_RX_RTS_EN
      if (q.size() >= 12)     m_rts = 1'b1;
      else if (q.size() <= 4) m_rts = 1'b0;
`else
      m_rts = 1'b0;
`endif
   endfunction

   function automatic void m_rx(input logic [7:0] d, input logic stopb);
      if (!stopb)                m_fe = 1'b1;
      else if (q.size() == DEPTH) m_ovr = 1'b1;
      else                       q.push_back(d);
      m_rts_update();
   endfunction

   task automatic bus_rd(input logic [1:0] a, input logic stb, output logic [7:0] v);
      @(negedge clk);
      cs = 1'b1; rwb = 1'b1; rs = a; strobe = stb;
      #1 v = dout;
      @(posedge clk);
      #1 strobe = 1'b0; rs = 2'd1;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; rwb = 1'b0; rs = a; din = d; strobe = 1'b1;
      @(posedge clk);
      #1 strobe = 1'b0; rwb = 1'b1; rs = 2'd1;
   endtask

   task automatic check_all(input string tag);
      logic [7:0] v;
      bus_rd(2'd1, 1'b0, v);
      chk({tag, ".status"}, v, m_status());
      bus_rd(2'd3, 1'b0, v);
      chk({tag, ".level"}, v, 8'(q.size()));
      chk({tag, ".irqb"}, {7'd0, irqb}, {7'd0, ~m_status() >> 7});
      chk({tag, ".rtsb"}, {7'd0, rtsb}, {7'd0, m_rts});
   endtask

   task automatic rd_pop(input string tag);
      logic [7:0] v, e;
      e = (q.size() != 0) ? q.pop_front() : 8'h00;
      m_rts_update();
      bus_rd(2'd0, 1'b1, v);
      chk(tag, v, e);
   endtask

   // One 8N1 frame; optional bus pop at cycle pop_at, optional reset at cycle rst_at.
   task automatic frame(input logic [7:0] d, input logic stopb, input int pop_at, input int rst_at,
                        output int lat, output logic [7:0] popped);
      int bl, total;
      logic [9:0] fr;
      bl = 16 * m_div;
      total = 10 * bl + 8;
      fr = {stopb, d, 1'b0};
      lat = -1;
      popped = 8'h00;
      for (int c = 0; c < total; c++) begin
         @(negedge clk);
         rxd = (c < 10 * bl) ? fr[c / bl] : 1'b1;
         if (c == rst_at) begin
            resb = 1'b0;
            #1;
            chk("rst_mid.dout", dout, 8'h00);
            chk("rst_mid.irqb", {7'd0, irqb}, 8'd1);
            chk("rst_mid.rtsb", {7'd0, rtsb}, 8'd0);
            rxd = 1'b1;
            repeat (3) @(negedge clk);
            resb = 1'b1;
            return;
         end
         cs = 1'b1; rwb = 1'b1;
         if (c == pop_at) begin
            rs = 2'd0; strobe = 1'b1;
            #1 popped = dout;
         end else begin
            rs = 2'd1; strobe = 1'b0;
         end
         @(posedge clk);
         #1;
         if (lat < 0 && c != pop_at && dout[0]) lat = c;
      end
      strobe = 1'b0; rs = 2'd1;
   endtask

   task automatic send(input logic [7:0] d, input logic stopb);
      int lat;
      logic [7:0] p;
      frame(d, stopb, -1, -1, lat, p);
      m_rx(d, stopb);
   endtask

   initial begin
      int lat, lat_ref;
      logic [7:0] v, p, d;

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk("reset.dout_cs0", dout, 8'h00);
      chk("reset.irqb", {7'd0, irqb}, 8'd1);
      chk("reset.rtsb", {7'd0, rtsb}, 8'd0);
      resb = 1'b1;
      cs = 1'b1;
      check_all("reset");
      bus_rd(2'd2, 1'b0, v);
      chk("reset.ctrl", v, 8'h00);

      // Default divisor
      d = 8'($urandom);
      send(d, 1'b1);
      check_all("defdiv");
      rd_pop("defdiv.data");

      // Divisor 1, ie=1, A5 with latency window
      bus_wr(2'd3, 8'd1); m_div = 1;
      bus_wr(2'd2, 8'hFF); m_ie = 1'b1;
      repeat (20) @(negedge clk);
      bus_rd(2'd2, 1'b0, v);
      chk("ctrl.ie", v, 8'h01);
      frame(8'hA5, 1'b1, -1, -1, lat_ref, p);
      m_rx(8'hA5, 1'b1);
      chk("a5.lat_window", {7'd0, (lat_ref >= 140 && lat_ref <= 165)}, 8'd1);
      check_all("a5");
      @(negedge clk); cs = 1'b0;
      #1 chk("a5.cs0_dout", dout, 8'h00);
      cs = 1'b1;
      rd_pop("a5.data");
      check_all("a5.after");

      // Glitch
      @(negedge clk); rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      repeat (40) @(negedge clk);
      check_all("glitch");

      // Framing error and clear
      send(8'h3C, 1'b0);
      check_all("fe");
      bus_wr(2'd1, 8'hFF); m_ovr = 1'b0; m_fe = 1'b0;
      check_all("fe.clear");

      // Overrun with 17 pushes, then drain
      for (int i = 0; i < 17; i++) begin
         send(8'(i), 1'b1);
         check_all("ovr.fill");
      end
      for (int i = 0; i < 17; i++) begin
         rd_pop("ovr.drain");
         check_all("ovr.drain_st");
      end
      bus_wr(2'd1, 8'h00); m_ovr = 1'b0; m_fe = 1'b0;

      // Push and pop on the same edge while full
      for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
      check_all("simul.full");
      frame(8'h10, 1'b1, lat_ref, -1, lat, p);
      chk("simul.popped", p, q.pop_front());
      m_rx(8'h10, 1'b1);
      check_all("simul.after");
      for (int i = 0; i < 16; i++) rd_pop("simul.drain");
      check_all("simul.empty");

      // Randomized traffic
      for (int it = 0; it < 30; it++) begin
         d = 8'($urandom);
         send(d, ($urandom_range(0, 7) != 0));
         repeat ($urandom_range(0, 3)) rd_pop("rand.data");
         if ($urandom_range(0, 5) == 0) begin
            bus_wr(2'd1, 8'($urandom)); m_ovr = 1'b0; m_fe = 1'b0;
         end
         check_all("rand");
      end
      while (q.size() != 0) rd_pop("rand.drain");
      bus_wr(2'd1, 8'h00); m_ovr = 1'b0; m_fe = 1'b0;

      // Divisor 2, then 0 acting as 1
      bus_wr(2'd3, 8'd2); m_div = 2;
      repeat (20) @(negedge clk);
      send(8'($urandom), 1'b1);
      rd_pop("div2.data");
      bus_wr(2'd3, 8'd0); m_div = 1;
      repeat (20) @(negedge clk);
      send(8'($urandom), 1'b1);
      rd_pop("div0.data");
      check_all("div");

      // Reset during data bit 3, then a clean 5A
      send(8'h77, 1'b1);
      check_all("pre_rst");
      frame(8'hC3, 1'b1, -1, 4 * 16 + 6, lat, p);
      q.delete(); m_ovr = 1'b0; m_fe = 1'b0; m_ie = 1'b0; m_rts = 1'b0; m_div = 13;
      check_all("post_rst");
      bus_wr(2'd3, 8'd1); m_div = 1;
      repeat (20) @(negedge clk);
      send(8'h5A, 1'b1);
      check_all("rst.5a");
      rd_pop("rst.5a_data");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/acia_rx_buffer.md
# acia_rx_buffer

Buffered serial receive port for the 65C816 glue logic. It sits between the board UART receive pin and the CPU data bus, beside the existing ACIA at its own register window. It converts 8N1 serial input to bytes with a 16x-oversampled receiver and queues them in a FIFO. The CPU reads them through a 4-register bus interface, and the block provides level-driven IRQ and RTS flow control.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; must be a power of two, at least 4.
- BAUD_DIV, 13: reset value of the divisor. One oversample tick occurs every BAUD_DIV clk cycles.
- RTS_HI, 12: FIFO level at or above which rtsb deasserts (goes high).
- RTS_LO, 4: FIFO level at or below which rtsb reasserts (goes low).

Ports:
- clk  in  1  system clock; the only clock in the block.
- resb  in  1  asynchronous, active-low reset.
- rxd  in  1  serial input; asynchronous to clk; idle high.
- cs  in  1  active-high chip select, already qualified by VPA/VDA and address decode.
- rwb  in  1  1 = read, 0 = write.
- rs  in  2  register select (address[1:0]).
- strobe  in  1  one-clk pulse marking the commit point of a bus access.
- din  in  8  write data.
- dout  out  8  read data; 8'h00 when cs=0.
- irqb  out  1  active-low interrupt request.
- rtsb  out  1  active-low request-to-send.

## Operation
Register map:
- rs=0 read: FIFO head byte. When strobe is high and FIFO is non-empty, the head is popped. When FIFO is empty, reads return 8'h00 and nothing is popped. Writes are ignored.
- rs=1 read: status {irq, 3'b0, ovr, fe, full, nempty}. A write with strobe clears ovr and fe; din is ignored.
- rs=2 read/write: control. Bit0 is ie (IRQ enable); other bits read 0. Reset value is 8'h00.
- rs=3 read: FIFO level, zero-extended. A write with strobe loads the divisor from din; a value of 0 is treated as 1.

Receiver:
- rxd passes through a 2-flop synchronizer before use.
- A tick counter reloads from the divisor and produces a one-clk tick when it reaches 0.
- Receiver states are IDLE, START, DATA, STOP. The sample counter counts ticks 0-15 within each state.
- IDLE: a synchronized falling edge moves to START and clears the sample counter.
- START: at tick 7, if rxd is low, go to DATA with the sample counter reset. If rxd is high (glitch), return to IDLE with no flag set.
- DATA: sample at each tick 15 relative to the start midpoint, LSB first. After 8 bits, go to STOP.
- STOP: sample at the mid-bit of the stop bit. A 1 pushes the byte. A 0 discards the byte and sets fe. Return to IDLE in the same cycle, so the next start edge is accepted immediately.

FIFO:
- Push while full: the byte is dropped and ovr is set. FIFO contents are unchanged.
- Push and pop in the same clk: both take effect and the level is unchanged. This also holds when the FIFO is full: the push is accepted and ovr is not set.
- Read and write pointers are log2(DEPTH) wide and wrap modulo DEPTH. The level counter is log2(DEPTH)+1 bits and saturates at neither end, because push-when-full and pop-when-empty are both blocked.

Interrupt: irq = ie & (nempty | ovr | fe), and irqb = ~irq.

## Timing
Reset values (resb low, asynchronous):
- FIFO is empty and both pointers are 0.
- ovr=0, fe=0, ie=0, divisor=BAUD_DIV, receiver state IDLE, synchronizer flops 1.
- Outputs: irqb=1, rtsb=0, dout=8'h00.

Latencies:
- rxd edge to detection: 2-3 clk (synchronizer).
- Stop-bit sample to nempty high: 1 clk. irqb falls in the same cycle as nempty.
- dout is combinational from cs, rs and registered state. A pop, flag clear or register write takes effect on the clk edge where strobe is high. The value visible on the next clk reflects the change.

Reset during a byte: the partial byte is lost and the receiver restarts in IDLE.

Divisor write during reception: takes effect at the next tick-counter reload; the current byte may be corrupted.

## Configuration
- ACIA_RX_RTS_EN defined: rtsb uses hysteresis.
  - It rises (deasserts) on the clk after level reaches RTS_HI or more.
  - It falls (reasserts) on the clk after level drops to RTS_LO or less.
  - Between the two thresholds it holds its value.
- ACIA_RX_RTS_EN undefined: rtsb is tied 0, and RTS_HI/RTS_LO are unused.

## Test plan
- Byte receive: divisor=1, send 8'hA5 in 8N1 at 16 clk/bit → nempty=1 about 152 clk after the start edge. With ie=1, irqb=0. Reading rs=0 returns 8'hA5; after that, level=0 and irqb=1.
- Glitch and framing:
  - A 4-clk low pulse on rxd leaves level=0 and fe=0.
  - 8'h3C with stop bit 0 leaves level=0 and sets fe=1 (status 8'h84 with ie=1).
  - Writing rs=1 clears the flags to status 8'h00.
- Overrun and wrap: push 17 bytes 8'h00 through 8'h10 with no reads. Expect full=1, ovr=1, level=16. Reads return 8'h00 through 8'h0F in order, then empty; dout=8'h00 with no pop.
- Simultaneous push/pop at full: strobe an rs=0 read on the same clk as the 17th push. Level stays 16, ovr=0, and the last entry is 8'h10.
- RTS hysteresis (ACIA_RX_RTS_EN defined):
  - Filling to 12 bytes drives rtsb to 1.
  - Draining to 5 keeps rtsb at 1.
  - Draining to 4 drives rtsb to 0.
- Reset mid-byte: assert resb low during DATA bit 3. All outputs take their reset values at once. A following clean 8'h5A is received correctly.
